// File: rtl/lwe_encrypt_row.sv
// lwe_encrypt_row: one LWE ciphertext component, the masked subset-sum of a key row plus scaled plaintext on the last row.
// Optional registered output: define ENCRYPT_REG_OUT_EN.
module lwe_encrypt_row #(
    parameter int PLAINTEXT_MODULUS  = 64,
    parameter int PLAINTEXT_WIDTH    = 6,
    parameter int DIMENSION          = 1,
    parameter int CIPHERTEXT_MODULUS = 1024,
    parameter int CIPHERTEXT_WIDTH   = 21,
    parameter int BIG_N              = 30
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PLAINTEXT_WIDTH-1:0]  plaintext,
    input  logic [CIPHERTEXT_WIDTH-1:0] publickey_row [BIG_N-1:0],
    input  logic [BIG_N-1:0]            noise_select,
    input  logic [DIMENSION:0]          row,
    output logic [CIPHERTEXT_WIDTH-1:0] ciphertext
);

    localparam int CW     = CIPHERTEXT_WIDTH;
    localparam int LVLS   = (BIG_N > 1) ? $clog2(BIG_N) : 0;
    localparam int LEAVES = 1 << LVLS;
    localparam int SHIFT  =
        $clog2(CIPHERTEXT_MODULUS / PLAINTEXT_MODULUS);
    localparam logic [DIMENSION:0] LAST_ROW =
        (DIMENSION + 1)'(DIMENSION);

    logic [CW-1:0] subset_sum;
    logic [CW-1:0] pt_term;
    logic [CW-1:0] ciphertext_d;

    // Balanced tree; leaves past BIG_N are padded with zero.
    for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
        localparam int NODES = LEAVES >> l;
        logic [CW-1:0] sum [NODES];
        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < NODES; i++) begin : g_in
                if (i < BIG_N) begin : g_key
                    assign sum[i] = noise_select[i]
                                  ? publickey_row[i] : '0;
                end else begin : g_pad
                    assign sum[i] = '0;
                end
            end
        end else begin : g_add
            for (genvar i = 0; i < NODES; i++) begin : g_node
                assign sum[i] = g_lvl[l-1].sum[2*i]
                              + g_lvl[l-1].sum[2*i+1];
            end
        end
    end

    assign subset_sum = g_lvl[LVLS].sum[0];

    always_comb begin
        pt_term = '0;
        if (row == LAST_ROW) begin
            pt_term = CW'(plaintext) << SHIFT;
        end
        ciphertext_d = subset_sum + pt_term;
    end

`ifdef ENCRYPT_REG_OUT_EN
    logic [CW-1:0] ciphertext_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ciphertext_q <= '0;
        end else begin
            ciphertext_q <= ciphertext_d;
        end
    end

    assign ciphertext = ciphertext_q;
`else
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst_n;
    assign ciphertext     = ciphertext_d;
`endif

endmodule

// File: tb/tb_lwe_encrypt_row.sv
// Self-checking bench for lwe_encrypt_row.
// Reference model is plain integer arithmetic on the subset-sum definition.
module tb_lwe_encrypt_row;

    localparam int PM  = 64;
    localparam int PW  = 6;
    localparam int DIM = 1;
    localparam int CM  = 1024;
    localparam int CW  = 21;
    localparam int N   = 30;

    logic          clk;
    logic          rst_n;
    logic [PW-1:0] plaintext;
    logic [CW-1:0] pk [N-1:0];
    logic [N-1:0]  ns;
    logic [DIM:0]  row;
    logic [CW-1:0] ciphertext;

    int passed;
    int total;

    int case1 [N] = '{124312, 58876, 59532, 3836, 94956,
                      161376, 20564, 92888, 126280, 72980,
                      101908, 656, 127920, 76980, 75340,
                      105124, 141104, 23352, 3772, 41656,
                      28700, 123820, 44344, 7052, 148976,
                      57300, 17448, 118900, 64352, 55432};

    lwe_encrypt_row #(
        .PLAINTEXT_MODULUS (PM),
        .PLAINTEXT_WIDTH   (PW),
        .DIMENSION         (DIM),
        .CIPHERTEXT_MODULUS(CM),
        .CIPHERTEXT_WIDTH  (CW),
        .BIG_N             (N)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .plaintext    (plaintext),
        .publickey_row(pk),
        .noise_select (ns),
        .row          (row),
        .ciphertext   (ciphertext)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CW-1:0] ref_ct();
        longint s;
        s = 0;
        for (int i = 0; i < N; i++) begin
            if (ns[i]) s += longint'(pk[i]);
        end
        if (int'(row) == DIM) s += longint'(plaintext) * (CM / PM);
        s = s % (longint'(1) << CW);
        return s[CW-1:0];
    endfunction

    task automatic load_case1();
        for (int i = 0; i < N; i++) pk[i] = case1[i];
        ns        = 30'b100110001101010110000011000010;
        plaintext = 6'd5;
        row       = '0;
    endtask

    // Wait until the output reflects the current inputs.
    task automatic settle();
`ifdef ENCRYPT_REG_OUT_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    task automatic test_reset();
        logic [CW-1:0] exp;
        rst_n = 1'b1;
        load_case1();
        #1;
        rst_n = 1'b0;
        #2;
`ifdef ENCRYPT_REG_OUT_EN
        exp = '0;
`else
        exp = 21'd752224;
`endif
        total++;
        if (ciphertext !== exp)
            $display("FAIL reset_hold got %0d want %0d",
                     ciphertext, exp);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (ciphertext !== exp)
            $display("FAIL reset_edge got %0d want %0d",
                     ciphertext, exp);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (ciphertext !== exp)
            $display("FAIL reset_release got %0d want %0d",
                     ciphertext, exp);
        else passed++;
        settle();
        total++;
        if (ciphertext !== 21'd752224)
            $display("FAIL reset_first got %0d want %0d",
                     ciphertext, 752224);
        else passed++;
    endtask

    task automatic test_directed();
        logic [CW-1:0] exp [6];
        string         nm  [6];
        nm[0] = "case1_row0";  exp[0] = 21'd752224;
        nm[1] = "case2_row1";  exp[1] = 21'd752304;
        nm[2] = "case3_pt63";  exp[2] = 21'd1008;
        nm[3] = "case3_row0";  exp[3] = 21'd0;
        nm[4] = "case4_wrap";  exp[4] = 21'd0;
        nm[5] = "case5_row2";  exp[5] = 21'd752224;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            load_case1();
            unique case (k)
                1: row = 2'd1;
                2: begin ns = '0; row = 2'd1; plaintext = 6'd63; end
                3: begin ns = '0; row = 2'd0; plaintext = 6'd63; end
                4: begin
                    for (int i = 0; i < N; i++) pk[i] = 21'h100000;
                    ns = '1;
                end
                5: row = 2'd2;
                default: ;
            endcase
            settle();
            total++;
            if (ciphertext !== exp[k])
                $display("FAIL %s got %0d want %0d",
                         nm[k], ciphertext, exp[k]);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [CW-1:0] exp;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (t % 10 == 9) pk[i] = '1;
                else pk[i] = CW'($urandom);
            end
            ns        = N'($urandom);
            if (t % 10 == 8) ns = '1;
            row       = 2'($urandom_range(0, 3));
            plaintext = PW'($urandom);
            exp       = ref_ct();
            settle();
            total++;
            if (ciphertext !== exp)
                $display("FAIL random_%0d got %0d want %0d",
                         t, ciphertext, exp);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [CW-1:0] exp;
        load_case1();
        for (int t = 0; t < 16; t++) begin
            ns        = N'($urandom);
            row       = 2'(t % 4);
            plaintext = PW'(t * 5);
            exp       = ref_ct();
            settle();
            total++;
            if (ciphertext !== exp)
                $display("FAIL b2b_%0d got %0d want %0d",
                         t, ciphertext, exp);
            else passed++;
        end
    endtask

    task automatic test_reset_midrun();
        logic [CW-1:0] exp;
        @(negedge clk);
        load_case1();
        row = 2'd1;
        settle();
        #2;
        rst_n = 1'b0;
        #1;
`ifdef ENCRYPT_REG_OUT_EN
        exp = '0;
`else
        exp = 21'd752304;
`endif
        total++;
        if (ciphertext !== exp)
            $display("FAIL midrun_reset got %0d want %0d",
                     ciphertext, exp);
        else passed++;
        row = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
`ifdef ENCRYPT_REG_OUT_EN
        exp = '0;
`else
        exp = 21'd752224;
`endif
        total++;
        if (ciphertext !== exp)
            $display("FAIL midrun_release got %0d want %0d",
                     ciphertext, exp);
        else passed++;
        settle();
        total++;
        if (ciphertext !== 21'd752224)
            $display("FAIL midrun_recover got %0d want %0d",
                     ciphertext, 752224);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
